// File: rtl/freq_meter.sv
// rtl/freq_meter.sv - gated rising-edge frequency counter against the 50 MHz clock
// Optional period measurement output enabled by macro FREQ_METER_PERIOD_MEAS_EN.
module freq_meter #(
  parameter int GATE_CYCLES = 50000000,
  parameter int COUNT_W     = 32
) (
  input  logic               clk_50mHz,
  input  logic               rst,
  input  logic               en,
  input  logic               sig_in,
  output logic [COUNT_W-1:0] freq_count,
  output logic               freq_valid,
  output logic               freq_ovf,
`ifdef FREQ_METER_PERIOD_MEAS_EN
  output logic [COUNT_W-1:0] period_count,
  output logic               period_valid,
`endif
  output logic               busy
);

  localparam int GW = $clog2(GATE_CYCLES);
  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [COUNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {IDLE, GATE} state_t;

  state_t             state;
  state_t             state_nxt;
  logic               s1, s2, s3;
  logic               rise;
  logic [GW-1:0]      gate_cnt;
  logic [COUNT_W-1:0] edge_cnt;
  logic               win_ovf;
  logic               counting;
  logic               win_close;
  logic               final_sat;
  logic [COUNT_W-1:0] close_count;

  assign rise      = s2 & ~s3;
  assign busy      = (state == GATE);
  assign counting  = (state == GATE) && en;
  assign win_close = counting && (gate_cnt == GATE_LAST);

  // A rise landing in the closing cycle still belongs to this window.
  assign final_sat   = rise && (edge_cnt == CNT_MAX);
  assign close_count = final_sat ? CNT_MAX : edge_cnt + {{(COUNT_W-1){1'b0}}, rise};

  always_ff @(posedge clk_50mHz) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (en)  state_nxt = GATE;
      GATE:    if (!en) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_50mHz) begin
    if (rst) begin
      s1         <= 1'b0;
      s2         <= 1'b0;
      s3         <= 1'b0;
      gate_cnt   <= '0;
      edge_cnt   <= '0;
      win_ovf    <= 1'b0;
      freq_count <= '0;
      freq_valid <= 1'b0;
      freq_ovf   <= 1'b0;
    end else begin
      s1         <= sig_in;
      s2         <= s1;
      s3         <= s2;
      freq_valid <= 1'b0;
      if (win_close) begin
        freq_count <= close_count;
        freq_ovf   <= win_ovf | final_sat;
        freq_valid <= 1'b1;
        gate_cnt   <= '0;
        edge_cnt   <= '0;
        win_ovf    <= 1'b0;
      end else if (counting) begin
        gate_cnt <= gate_cnt + GW'(1);
        if (rise) begin
          if (edge_cnt == CNT_MAX) begin
            win_ovf <= 1'b1;
          end else begin
            edge_cnt <= edge_cnt + COUNT_W'(1);
          end
        end
      end else begin
        // Idle or aborting: partial window is thrown away.
        gate_cnt <= '0;
        edge_cnt <= '0;
        win_ovf  <= 1'b0;
      end
    end
  end

`ifdef FREQ_METER_PERIOD_MEAS_EN
  logic [COUNT_W-1:0] per_cnt;
  logic               per_armed;

  always_ff @(posedge clk_50mHz) begin
    if (rst) begin
      per_cnt      <= '0;
      per_armed    <= 1'b0;
      period_count <= '0;
      period_valid <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      if (counting) begin
        if (rise) begin
          // First rise of an enable session only arms the counter.
          if (per_armed) begin
            period_count <= (per_cnt == CNT_MAX) ? CNT_MAX : per_cnt + COUNT_W'(1);
            period_valid <= 1'b1;
          end
          per_armed <= 1'b1;
          per_cnt   <= '0;
        end else if (per_cnt != CNT_MAX) begin
          per_cnt <= per_cnt + COUNT_W'(1);
        end
      end else begin
        per_cnt   <= '0;
        per_armed <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_freq_meter.sv
// tb/tb_freq_meter.sv - scoreboard bench for freq_meter (GATE_CYCLES=100, COUNT_W=8 and 4)
module tb_freq_meter;

  typedef struct {
    int c;
    int o;
    int age;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic sig_in = 1'b0;

  logic [7:0] count8;
  logic       valid8, ovf8, busy8;
  logic [3:0] count4;
  logic       valid4, ovf4, busy4;
`ifdef FREQ_METER_PERIOD_MEAS_EN
  logic [7:0] pcount8;
  logic       pvalid8;
  logic [3:0] pcount4;
  logic       pvalid4;
  int         pv_seen = 0;
`endif

  exp_t q8[$];
  exp_t q4[$];
  int   n_tests = 0;
  int   n_fail = 0;
  int   age8 = 0;
  int   age4 = 0;
  int   mode = 0;
  int   ph = 0;

  always #10 clk = ~clk;

  freq_meter #(.GATE_CYCLES(100), .COUNT_W(8)) u_dut8 (
    .clk_50mHz(clk), .rst(rst), .en(en), .sig_in(sig_in),
    .freq_count(count8), .freq_valid(valid8), .freq_ovf(ovf8),
`ifdef FREQ_METER_PERIOD_MEAS_EN
    .period_count(pcount8), .period_valid(pvalid8),
`endif
    .busy(busy8)
  );

  freq_meter #(.GATE_CYCLES(100), .COUNT_W(4)) u_dut4 (
    .clk_50mHz(clk), .rst(rst), .en(en), .sig_in(sig_in),
    .freq_count(count4), .freq_valid(valid4), .freq_ovf(ovf4),
`ifdef FREQ_METER_PERIOD_MEAS_EN
    .period_count(pcount4), .period_valid(pvalid4),
`endif
    .busy(busy4)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // mode 0/1 hold the input static, mode >= 2 is the period in clocks (half high, half low)
  always @(posedge clk) begin
    #2;
    if (mode == 0) sig_in = 1'b0;
    else if (mode == 1) sig_in = 1'b1;
    else begin
      sig_in = (ph < mode / 2);
      ph = (ph + 1) % mode;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (busy8) age8++; else age8 = 0;
    if (valid8) begin
      if (q8.size() == 0) check("dut8 unexpected valid", 1, 0);
      else begin
        e = q8.pop_front();
        check("dut8 freq_count", 32'(count8), e.c);
        check("dut8 freq_ovf", 32'(ovf8), e.o);
        check("dut8 valid cycle", age8, e.age);
      end
    end
`ifdef FREQ_METER_PERIOD_MEAS_EN
    if (pvalid8) begin
      pv_seen++;
      check("dut8 period_count", 32'(pcount8), mode);
    end
`endif
  end

  always @(negedge clk) begin
    exp_t e;
    if (busy4) age4++; else age4 = 0;
    if (valid4) begin
      if (q4.size() == 0) check("dut4 unexpected valid", 1, 0);
      else begin
        e = q4.pop_front();
        check("dut4 freq_count", 32'(count4), e.c);
        check("dut4 freq_ovf", 32'(ovf4), e.o);
        check("dut4 valid cycle", age4, e.age);
      end
    end
  end

  task automatic push(input int c8, input int o8, input int c4, input int o4, input int age);
    exp_t e;
    e.age = age;
    e.c = c8; e.o = o8; q8.push_back(e);
    e.c = c4; e.o = o4; q4.push_back(e);
  endtask

  task automatic check_zero(input string tag);
    check({tag, " dut8 freq_count"}, 32'(count8), 0);
    check({tag, " dut8 freq_valid"}, 32'(valid8), 0);
    check({tag, " dut8 freq_ovf"}, 32'(ovf8), 0);
    check({tag, " dut8 busy"}, 32'(busy8), 0);
    check({tag, " dut4 freq_count"}, 32'(count4), 0);
    check({tag, " dut4 freq_ovf"}, 32'(ovf4), 0);
    check({tag, " dut4 busy"}, 32'(busy4), 0);
  endtask

  task automatic set_mode(input int m);
    @(posedge clk);
    #1 mode = m;
    repeat (6) @(posedge clk);
  endtask

  // en rises at P0+1; the IDLE->GATE edge is the next one, and en is dropped so
  // that it is sampled exactly m edges after that transition edge.
  task automatic session(input int m);
    @(posedge clk);
    #1 en = 1'b1;
    repeat (m) @(posedge clk);
    #1 en = 1'b0;
  endtask

  task automatic drain(input string tag);
    repeat (4) @(posedge clk);
    check({tag, " dut8 windows pending"}, q8.size(), 0);
    check({tag, " dut4 windows pending"}, q4.size(), 0);
    q8.delete();
    q4.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    en = 1'b1;
    mode = 4;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      check_zero("reset");
    end
    rst = 1'b0;
    en = 1'b0;
    set_mode(10);

    push(10, 0, 10, 0, 101); push(10, 0, 10, 0, 201); push(10, 0, 10, 0, 301);
    session(303);
    drain("basic");

    set_mode(0);
    push(0, 0, 0, 0, 101); push(0, 0, 0, 0, 201);
    session(203);
    drain("static0");

    set_mode(1);
    push(0, 0, 0, 0, 101); push(0, 0, 0, 0, 201);
    session(203);
    drain("static1");

    set_mode(4);
    push(25, 0, 15, 1, 101); push(25, 0, 15, 1, 201);
    session(203);
    drain("saturate");
    set_mode(10);
    push(10, 0, 10, 0, 101);
    session(103);
    drain("desaturate");

    push(10, 0, 10, 0, 101);
    session(151);
    @(posedge clk);
    #1;
    check("abort dut8 busy", 32'(busy8), 0);
    check("abort dut8 freq_valid", 32'(valid8), 0);
    check("abort dut8 freq_count", 32'(count8), 10);
    check("abort dut4 freq_count", 32'(count4), 10);
    repeat (150) @(posedge clk);
    check("abort dut8 freq_count held", 32'(count8), 10);
    push(10, 0, 10, 0, 101);
    session(103);
    drain("abort");

    set_mode(0);
    push(1, 0, 1, 0, 101); push(0, 0, 0, 0, 201);
    @(posedge clk);
    #1 en = 1'b1;
    repeat (98) @(posedge clk);
    #1 mode = 1;
    repeat (105) @(posedge clk);
    #1 en = 1'b0;
    drain("last-cycle rise");

    set_mode(10);
    push(10, 0, 10, 0, 101);
    @(posedge clk);
    #1 en = 1'b1;
    repeat (141) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    check_zero("mid reset");
    en = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    drain("mid reset");

`ifdef FREQ_METER_PERIOD_MEAS_EN
    check("period pulses seen", 32'(pv_seen > 0), 1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/freq_meter.md
Name: freq_meter

Overview:
- Frequency counter: measures the frequency of an asynchronous, slow input signal against the 50 MHz system clock.
- Counts rising edges of sig_in over a fixed gate window of GATE_CYCLES clock cycles (default 1 s) and presents the result with a valid strobe.
- Complements the existing divider. The divider generates a known low-rate clock from 50 MHz; this block recovers an unknown rate using the same 50 MHz reference.
- Used for board bring-up, self-check of divider outputs, and feeding display/LED logic.

Parameters:
GATE_CYCLES, 50000000, gate window length in clk_50mHz cycles (>=2)
COUNT_W, 32, width of edge counter and result; saturating

Ports:
clk_50mHz  input  1  system clock, 50 MHz
rst  input  1  synchronous reset, active-high
en  input  1  measurement enable; level-sensitive
sig_in  input  1  signal under measurement; asynchronous to clk_50mHz
freq_count  output  COUNT_W  rising edges counted in last completed window
freq_valid  output  1  one-cycle pulse: freq_count/freq_ovf updated
freq_ovf  output  1  last completed window saturated the counter
busy  output  1  high while in GATE state

Behaviour:
- Interface: one clock, clk_50mHz. Reset rst is synchronous and active-high, sampled on the clk_50mHz rising edge; it overrides everything else.
- Reset values: freq_count=0, freq_valid=0, freq_ovf=0, busy=0, state=IDLE. Gate counter, edge counter and synchronizer flops are all cleared to 0.
- Input path: sig_in passes through a 2-flop synchronizer (s1, s2) plus a history flop s3. rise = s2 & ~s3, one cycle wide per input rising edge.
- Input constraint: sig_in high and low phases must each be >=2 clk cycles for exact counting; faster inputs are undefined.
- FSM states: IDLE, GATE.
- IDLE:
  - busy=0; gate_cnt=0; edge_cnt=0.
  - en=1 -> GATE on the next edge.
- GATE:
  - busy=1.
  - gate_cnt runs 0..GATE_CYCLES-1, one increment per cycle.
  - edge_cnt increments on each cycle with rise=1 and saturates at 2^COUNT_W-1.
  - win_ovf is set if rise=1 occurs while edge_cnt is already at max.
- Window close, on the cycle with gate_cnt==GATE_CYCLES-1 and en=1:
  - freq_count <= edge_cnt + rise, saturating; a rise in the last cycle belongs to the closing window.
  - freq_ovf <= win_ovf, or saturation caused by this final add.
  - freq_valid is high exactly the next cycle, for one cycle.
  - gate_cnt, edge_cnt and win_ovf clear; the FSM stays in GATE, so windows run back-to-back with no dead cycle.
- en=0 in any GATE cycle, including the last: abort to IDLE on the next edge. No freq_valid; freq_count/freq_ovf hold the previous result; partial counts are discarded.
- Re-enable always starts a fresh, full window from gate_cnt=0.
- Window length is exactly GATE_CYCLES cycles. First freq_valid appears GATE_CYCLES+1 cycles after the IDLE->GATE transition edge.
- Synchronizer flops run in every state, so an edge already in flight is counted only if rise falls inside a GATE cycle.

Optional Feature:
- Macro: FREQ_METER_PERIOD_MEAS_EN.
- Defined:
  - Adds output period_count (COUNT_W bits; reset 0) and period_valid (1 bit; reset 0).
  - A period counter increments every GATE cycle and saturates.
  - On each rise in GATE: if a previous rise has been seen in the current enable session, period_count <= counter+1 and period_valid pulses the next cycle. The counter then resets to 0.
  - The first rise after entering GATE only arms the counter and produces no period_valid.
  - Abort or reset disarms it.
- Not defined: these ports and logic do not exist; behaviour is otherwise identical.

Test Plan (GATE_CYCLES=100, COUNT_W=8 unless stated):
- Reset: rst=1 for 3 cycles with en=1 and sig_in toggling -> freq_count=0, freq_valid=0, freq_ovf=0, busy=0 throughout.
- Basic count: en=1, sig_in period 10 cycles (5H/5L) -> freq_valid pulses every 100 cycles, first at 101 cycles after entering GATE; freq_count=10 and freq_ovf=0 in every window.
- Static input: sig_in held 0, then held 1 -> freq_count=0 each window.
- Saturation: COUNT_W=4, sig_in period 4 cycles (25 edges/window) -> freq_count=15, freq_ovf=1. Next window at period 10 -> freq_count=10, freq_ovf=0.
- Abort: en dropped at gate_cnt=50 after one completed window of 10 -> no freq_valid; freq_count stays 10; busy=0 the next cycle. en back to 1 -> full 100-cycle window, then freq_count=10.
- Boundary/reset: a rise on gate_cnt==99 is counted in the closing window. rst asserted at gate_cnt=40 -> all outputs 0 next cycle, FSM in IDLE. With FREQ_METER_PERIOD_MEAS_EN, period 10 input -> period_count=10 from the second edge onward.
